// File: rtl/peridot_uart_txarb_pkg.sv
// peridot_uart_txarb_pkg: framing constants and FSM encoding shared with the RX-side demux
package peridot_uart_txarb_pkg;
  localparam logic [7:0] MARKER_BYTE_DEF = 8'h7C;
  localparam logic [7:0] ESCAPE_BYTE_DEF = 8'h7D;
  localparam logic [7:0] ESC_XOR = 8'h20;
  typedef enum logic [2:0] {ST_IDLE, ST_MARK, ST_CHNUM, ST_DATA, ST_ESC2} state_t;
endpackage

// File: rtl/peridot_rr_arbiter.sv
// peridot_rr_arbiter: combinational round-robin pick starting at the rr pointer
module peridot_rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [1:0]   gnt,
  output logic         any
);
  // scan downward so the lowest offset from ptr is the one that sticks
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) gnt = 2'((int'(ptr) + i) % N);
  end
  assign any = |req;
endmodule

// File: rtl/peridot_uart_txarb.sv
// peridot_uart_txarb: round-robin byte-stream arbiter with channel markers and escaping
module peridot_uart_txarb
  import peridot_uart_txarb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter logic [7:0] MARKER_BYTE = MARKER_BYTE_DEF,
  parameter logic [7:0] ESCAPE_BYTE = ESCAPE_BYTE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     in_valid,
  input  logic [8*NUM_REQ-1:0]   in_data,
  input  logic [NUM_REQ-1:0]     in_endofpacket,
  output logic [NUM_REQ-1:0]     in_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  input  logic                   out_ready,
  output logic [1:0]             grant_channel,
  output logic                   busy
);
  state_t state, state_n;
  logic [1:0] ptr, gnt, last_ch;
  logic last_vld, any, load_en, ld, acc, sel_v, sel_e, eop_f, esc;
  logic [7:0] ld_data, sel_d, pend;
  peridot_rr_arbiter #(.N(NUM_REQ)) u_arb (.req(in_valid), .ptr(ptr), .gnt(gnt), .any(any));
  assign load_en = !out_valid || out_ready;
  assign busy = (state != ST_IDLE) || out_valid;
  assign acc = (state == ST_DATA) && sel_v && load_en;
  assign esc = (sel_d == MARKER_BYTE) || (sel_d == ESCAPE_BYTE);
  // mux the granted source and steer its ready
  always_comb begin
    sel_v = 1'b0;
    sel_d = '0;
    sel_e = 1'b0;
    in_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_channel == 2'(i)) begin
        sel_v = in_valid[i];
        sel_d = in_data[8*i +: 8];
        sel_e = in_endofpacket[i];
        in_ready[i] = (state == ST_DATA) && load_en;
      end
  end
  // next state and the byte to load into the output register
  always_comb begin
    state_n = state;
    ld = 1'b0;
    ld_data = '0;
    case (state)
      ST_IDLE:  if (any) state_n = (last_vld && gnt == last_ch) ? ST_DATA : ST_MARK;
      ST_MARK:  if (load_en) begin ld = 1'b1; ld_data = MARKER_BYTE; state_n = ST_CHNUM; end
      ST_CHNUM: if (load_en) begin ld = 1'b1; ld_data = {6'b0, grant_channel}; state_n = ST_DATA; end
      ST_DATA:  if (acc) begin
        ld = 1'b1;
        ld_data = esc ? ESCAPE_BYTE : sel_d;
        state_n = esc ? ST_ESC2 : sel_e ? ST_IDLE : ST_DATA;
      end
      ST_ESC2:  if (load_en) begin ld = 1'b1; ld_data = pend; state_n = eop_f ? ST_IDLE : ST_DATA; end
      default:  state_n = ST_IDLE;
    endcase
  end
  // state, output register, grant bookkeeping and escape pending byte
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      out_valid <= 1'b0;
      out_data <= '0;
      grant_channel <= '0;
      ptr <= '0;
      last_vld <= 1'b0;
      last_ch <= '0;
      pend <= '0;
      eop_f <= 1'b0;
    end else begin
      state <= state_n;
      if (load_en) out_valid <= ld;
      if (load_en && ld) out_data <= ld_data;
      if (state == ST_IDLE && any) grant_channel <= gnt;
      if (state == ST_CHNUM && load_en) begin
        last_vld <= 1'b1;
        last_ch <= grant_channel;
      end
      if (acc) begin
        pend <= sel_d ^ ESC_XOR;
        eop_f <= sel_e;
        if (sel_e) ptr <= 2'((int'(grant_channel) + 1) % NUM_REQ);
      end
    end
  end
endmodule

// File: tb/tb_peridot_uart_txarb.sv
// tb_peridot_uart_txarb: scoreboard bench for the two-requester arbiter/framer
module tb_peridot_uart_txarb;
  typedef struct packed {logic [7:0] d; logic e; logic h;} item_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] in_valid = '0;
  logic [15:0] in_data = '0;
  logic [1:0] in_endofpacket = '0;
  logic [1:0] in_ready;
  logic out_valid;
  logic [7:0] out_data;
  logic out_ready = 1'b1;
  logic [1:0] grant_channel;
  logic busy;
  int n_chk = 0;
  int n_fail = 0;
  item_t src0[$];
  item_t src1[$];
  logic [7:0] sb[$];
  int pause0 = 0;
  int pause1 = 0;
  logic rand_rdy = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] held = '0;
  logic esc_chk0 = 1'b0;
  logic esc_chk1 = 1'b0;

  peridot_uart_txarb dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_endofpacket(in_endofpacket), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .grant_channel(grant_channel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst_now);
    logic a0, a1;
    logic [7:0] exp;
    item_t it;
    @(negedge clk);
    reset = rst_now;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    in_valid = '0;
    in_data = '0;
    in_endofpacket = '0;
    if (!rst_now && pause0 == 0 && src0.size() > 0) begin
      in_valid[0] = 1'b1; in_data[7:0] = src0[0].d; in_endofpacket[0] = src0[0].e;
    end
    if (!rst_now && pause1 == 0 && src1.size() > 0) begin
      in_valid[1] = 1'b1; in_data[15:8] = src1[0].d; in_endofpacket[1] = src1[0].e;
    end
    #1;
    if (stall_prev) begin
      n_chk++;
      if (!(out_valid === 1'b1 && out_data === held)) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", out_valid, out_data, held);
      end
    end
    if (esc_chk0) begin
      n_chk++;
      if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL esc2_ready0: got %b required 0", in_ready[0]); end
    end
    if (esc_chk1) begin
      n_chk++;
      if (in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL esc2_ready1: got %b required 0", in_ready[1]); end
    end
    esc_chk0 = 1'b0;
    esc_chk1 = 1'b0;
    if (out_valid === 1'b1 && out_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_byte: unexpected byte %h, required none", out_data);
      end else begin
        exp = sb.pop_front();
        if (out_data !== exp) begin n_fail++; $display("FAIL out_byte: got %h required %h", out_data, exp); end
      end
    end
    stall_prev = out_valid === 1'b1 && !out_ready;
    held = out_data;
    a0 = in_valid[0] && in_ready[0] === 1'b1;
    a1 = in_valid[1] && in_ready[1] === 1'b1;
    @(posedge clk);
    if (pause0 > 0) pause0--;
    if (pause1 > 0) pause1--;
    if (a0) begin
      it = src0.pop_front();
      if (it.h) pause0 = 5;
      esc_chk0 = it.d == 8'h7C || it.d == 8'h7D;
    end
    if (a1) begin
      it = src1.pop_front();
      if (it.h) pause1 = 5;
      esc_chk1 = it.d == 8'h7C || it.d == 8'h7D;
    end
    if (rst_now) begin stall_prev = 1'b0; esc_chk0 = 1'b0; esc_chk1 = 1'b0; end
  endtask

  task automatic drain(input string name);
    int c;
    for (c = 0; c < 400; c++) begin
      if (src0.size() == 0 && src1.size() == 0 && sb.size() == 0 && out_valid === 1'b0) break;
      step(1'b0);
    end
    n_chk++;
    if (c >= 400) begin
      n_fail++;
      $display("FAIL %s_drain: timeout, %0d bytes still expected, required 0", name, sb.size());
      src0.delete(); src1.delete(); sb.delete();
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic e, input logic h);
    item_t it;
    it = '{d: d, e: e, h: h};
    if (ch == 0) src0.push_back(it); else src1.push_back(it);
  endtask

  task automatic push_exp(input logic [7:0] d);
    sb.push_back(d);
  endtask

  task automatic test_reset;
    step(1'b1);
    step(1'b1);
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_chk++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h required 00", out_data); end
    n_chk++;
    if (in_ready !== 2'b00) begin n_fail++; $display("FAIL rst_in_ready: got %b required 00", in_ready); end
    n_chk++;
    if (grant_channel !== 2'd0) begin n_fail++; $display("FAIL rst_grant: got %0d required 0", grant_channel); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
  endtask

  task automatic test_single;
    push(0, 8'h41, 1'b0, 1'b0);
    push(0, 8'h42, 1'b1, 1'b0);
    push_exp(8'h7C); push_exp(8'h00); push_exp(8'h41); push_exp(8'h42);
    drain("single");
    #1;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b required 0", busy); end
  endtask

  task automatic test_escape;
    push(1, 8'h7C, 1'b0, 1'b0);
    push(1, 8'h7D, 1'b0, 1'b0);
    push(1, 8'h55, 1'b1, 1'b0);
    push_exp(8'h7C); push_exp(8'h01); push_exp(8'h7D); push_exp(8'h5C);
    push_exp(8'h7D); push_exp(8'h5D); push_exp(8'h55);
    drain("escape");
    #1;
    n_chk++;
    if (grant_channel !== 2'd1) begin n_fail++; $display("FAIL escape_grant: got %0d required 1", grant_channel); end
  endtask

  task automatic test_back_to_back;
    step(1'b1);
    push(0, 8'h01, 1'b0, 1'b0); push(0, 8'h02, 1'b1, 1'b0);
    push(0, 8'h03, 1'b0, 1'b0); push(0, 8'h04, 1'b1, 1'b0);
    push(1, 8'h11, 1'b0, 1'b0); push(1, 8'h12, 1'b1, 1'b0);
    push_exp(8'h7C); push_exp(8'h00); push_exp(8'h01); push_exp(8'h02);
    push_exp(8'h7C); push_exp(8'h01); push_exp(8'h11); push_exp(8'h12);
    push_exp(8'h7C); push_exp(8'h00); push_exp(8'h03); push_exp(8'h04);
    drain("b2b");
  endtask

  task automatic test_same_channel;
    step(1'b1);
    push(0, 8'h21, 1'b0, 1'b0); push(0, 8'h22, 1'b1, 1'b0);
    push(0, 8'h23, 1'b0, 1'b0); push(0, 8'h24, 1'b1, 1'b0);
    push_exp(8'h7C); push_exp(8'h00); push_exp(8'h21); push_exp(8'h22);
    push_exp(8'h23); push_exp(8'h24);
    drain("same");
  endtask

  task automatic test_packet_lock;
    step(1'b1);
    rand_rdy = 1'b1;
    push(0, 8'h31, 1'b0, 1'b1); push(0, 8'h32, 1'b0, 1'b0); push(0, 8'h33, 1'b1, 1'b0);
    push(1, 8'h41, 1'b0, 1'b0); push(1, 8'h42, 1'b1, 1'b0);
    push_exp(8'h7C); push_exp(8'h00); push_exp(8'h31); push_exp(8'h32); push_exp(8'h33);
    push_exp(8'h7C); push_exp(8'h01); push_exp(8'h41); push_exp(8'h42);
    drain("lock");
    rand_rdy = 1'b0;
  endtask

  task automatic test_reset_mid_packet;
    int c;
    step(1'b1);
    push(0, 8'hA1, 1'b0, 1'b0); push(0, 8'hA2, 1'b0, 1'b0); push(0, 8'hA3, 1'b1, 1'b0);
    push_exp(8'h7C); push_exp(8'h00); push_exp(8'hA1);
    for (c = 0; c < 50 && src0.size() != 2; c++) step(1'b0);
    n_chk++;
    if (src0.size() != 2) begin n_fail++; $display("FAIL midrst_first_byte: remaining %0d required 2", src0.size()); end
    step(1'b1);
    src0.delete();
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy); end
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL midrst_pending: %0d bytes left, required 0", sb.size()); sb.delete(); end
    push(0, 8'hB1, 1'b0, 1'b0); push(0, 8'hB2, 1'b1, 1'b0);
    push_exp(8'h7C); push_exp(8'h00); push_exp(8'hB1); push_exp(8'hB2);
    drain("midrst");
  endtask

  initial begin
    test_reset;
    test_single;
    test_escape;
    test_back_to_back;
    test_same_channel;
    test_packet_lock;
    test_reset_mid_packet;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/peridot_uart_txarb.md
Name: peridot_uart_txarb

Overview:
- Round-robin arbiter and byte framer that shares one UART transmit byte stream between NUM_REQ Avalon-ST byte sources.
- Sits between the host-bridge packet sources and the UART transmit phy, on the same clock as the phys.
- Holds a grant for a whole packet, up to and including the EOP beat.
- Inserts a channel-select sequence whenever the owning channel changes, and escapes reserved byte values so the far-end receiver can demultiplex the stream.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 1..4.
- MARKER_BYTE, 8'h7C, channel-select marker, followed by the channel number byte.
- ESCAPE_BYTE, 8'h7D, escape prefix; the escaped byte is sent as data XOR 8'h20.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_REQ  per-requester byte valid.
- in_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- in_endofpacket  in  NUM_REQ  per-requester last byte of packet.
- in_ready  out  NUM_REQ  per-requester byte accepted (valid && ready).
- out_valid  out  1  byte valid to the TX phy.
- out_data  out  8  byte to the TX phy.
- out_ready  in  1  TX phy accepts out_data.
- grant_channel  out  2  channel currently or last granted.
- busy  out  1  high while a packet is locked or output bytes are pending.

Behaviour:
- Reset values (synchronous, on reset=1):
  - out_valid=0, out_data=8'h00, in_ready=0, grant_channel=0, busy=0.
  - FSM=IDLE, rr pointer=0, last_channel=invalid. Invalid forces a marker before the first packet.
- Output register:
  - out_valid/out_data are registered.
  - The output register may load when load_en = (!out_valid || out_ready).
  - out_data must be held stable while out_valid && !out_ready.
- FSM states: IDLE, MARK, CHNUM, DATA, ESC2.
- IDLE:
  - If any in_valid is high, grant the first requester at or after rr pointer, searching upward modulo NUM_REQ. Latch it into grant_channel.
  - If granted channel != last_channel, go to MARK; otherwise go to DATA.
  - No bytes are accepted in IDLE.
- MARK:
  - On load_en, load MARKER_BYTE and go to CHNUM.
- CHNUM:
  - On load_en, load {6'b0, grant_channel}, set last_channel=grant_channel, go to DATA.
- DATA:
  - in_ready[grant_channel] = load_en. This is combinational from out_ready; all other in_ready are 0.
  - On accept of a byte d:
    - If d is MARKER_BYTE or ESCAPE_BYTE: load ESCAPE_BYTE, store d^8'h20 in the pending register, go to ESC2.
    - Otherwise: load d and stay in DATA.
    - If in_endofpacket is set on the accepted beat: set rr pointer = grant_channel+1 (mod NUM_REQ). Go to IDLE, or finish ESC2 first and then go to IDLE.
- ESC2:
  - On load_en, load the pending byte.
  - Go to IDLE if the EOP flag was captured; otherwise go back to DATA.
  - in_ready is 0 in ESC2.
- Latency: an accepted byte appears on out_valid/out_data on the next clock. An escaped byte takes 2 output beats.
- Packet lock: other requesters are never granted mid-packet, even while the owning source idles with in_valid=0.
- Simultaneous requests: round-robin fairness; a continuously requesting channel waits at most NUM_REQ-1 packets.
- Backpressure: any state may stall indefinitely on out_ready=0 with no loss or duplication.
- NUM_REQ=1: grant_channel is always 0, and the marker is emitted only once after reset.
- busy = (state != IDLE) || out_valid.
- Reset mid-packet: the FSM and output drop immediately (out_valid=0 the next cycle). The partial packet is abandoned, and the marker is re-sent before the next packet.

Decomposition:
- Shared package, used by the matching RX-side demux:
  - MARKER_BYTE and ESCAPE_BYTE defaults.
  - Escape XOR constant 8'h20.
  - FSM state encoding.
- One sub-module: peridot_rr_arbiter.
  - Combinational round-robin pick from a request vector and rr pointer.
  - Outputs a grant index and an any-request flag.
  - Reusable by other host-bridge muxes.

Test Plan:
- Single requester 0, bytes 8'h41,8'h42 with EOP on 8'h42, out_ready=1 -> out stream 7C,00,41,42; busy falls after 42 is accepted.
- Requester 1 sends 7C,7D,55 with EOP on 55 -> out stream 7C,01,7D,5C,7D,5D,55; in_ready[1] is low during the ESC2 beats.
- Requesters 0 and 1 each assert 2-byte packets in the same cycle from reset -> ch0 packet first, then 7C,01 and the ch1 packet. A second back-to-back ch0 packet follows ch1, proving rotation.
- Same channel sends two consecutive packets with no competitor -> the marker appears only before the first packet.
- Requester 0 mid-packet drops in_valid for 5 cycles while requester 1 is valid -> no ch1 bytes until ch0's EOP beat. Toggle out_ready randomly: out_data is held stable while stalled and the byte sequence is unchanged.
- Assert reset for 1 cycle after the 1st byte of a 3-byte packet -> out_valid=0 and busy=0 the next cycle; the next packet from the same channel starts with 7C,00.
